// File: rtl/bcg_line_fetcher_if.sv
// Fetcher-side bus bundle: byte-VRAM read port, palette nibble read port and
// the outgoing pixel stream towards the line-buffer writer.
interface bcg_line_fetcher_if;
    logic [12:0] raddr;
    logic        rd;
    logic [7:0]  rdata;
    logic        rds;
    logic        rsel;
    logic [3:0]  rdata2;
    logic        pix_valid;
    logic        pix_ready;
    logic [8:0]  pix_x;
    logic [5:0]  pix_color;
    logic        pix_prio;

    modport master (
        output raddr, rd, rds, rsel, pix_valid, pix_x, pix_color, pix_prio,
        input  rdata, rdata2, pix_ready
    );

    modport slave (
        input  raddr, rd, rds, rsel, pix_valid, pix_x, pix_color, pix_prio,
        output rdata, rdata2, pix_ready
    );
endinterface

// File: rtl/bcg_line_fetcher.sv
// Background scan-line fetcher: per tile reads map byte, palette nibble and two
// 2bpp texture bytes, then streams 8 coloured pixels over a valid/ready link.
module bcg_line_fetcher #(
    parameter int TILES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       line_start,
    input  logic [7:0]                 line_y,
    output logic                       busy,
    output logic                       line_done,
    bcg_line_fetcher_if.master         bus
);

    localparam logic [5:0] LAST_TX = 6'(TILES - 1);

    typedef enum logic [2:0] {IDLE, RMAP, RT0, RT1, LAT, EMIT, DONE} state_t;

    state_t      state, next;
    logic [5:0]  tx;
    logic [4:0]  ty;
    logic [2:0]  yl;
    logic [2:0]  i;
    logic [7:0]  tile;
    logic [3:0]  pal;
    logic [7:0]  b0, b1;
    logic [7:0]  cur_byte;
    logic [1:0]  cur_pix;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    // Datapath registers; rdata/rdata2 are only captured in their latch states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx   <= '0;
            ty   <= '0;
            yl   <= '0;
            i    <= '0;
            tile <= '0;
            pal  <= '0;
            b0   <= '0;
            b1   <= '0;
        end else begin
            case (state)
                IDLE: if (line_start) begin
                    ty <= line_y[7:3];
                    yl <= line_y[2:0];
                    tx <= '0;
                end
                RT0: begin
                    tile <= bus.rdata;
                    pal  <= bus.rdata2;
                end
                RT1: b0 <= bus.rdata;
                LAT: begin
                    b1 <= bus.rdata;
                    i  <= '0;
                end
                EMIT: if (bus.pix_ready) begin
                    i <= i + 3'd1;
                    if (i == 3'd7 && tx != LAST_TX) tx <= tx + 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cur_byte = i[2] ? b1 : b0;
        cur_pix  = '0;
        case (i[1:0])
            2'd0: cur_pix = cur_byte[7:6];
            2'd1: cur_pix = cur_byte[5:4];
            2'd2: cur_pix = cur_byte[3:2];
            2'd3: cur_pix = cur_byte[1:0];
            default: ;
        endcase
    end

    // The palette store shares raddr with the map read: it sees the map
    // address together with rsel in the RMAP cycle.
    always_comb begin
        next          = state;
        line_done     = 1'b0;
        bus.raddr     = '0;
        bus.rd        = 1'b0;
        bus.rds       = 1'b0;
        bus.rsel      = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_x     = '0;
        bus.pix_color = '0;
        bus.pix_prio  = 1'b0;
        case (state)
            IDLE: if (line_start) next = RMAP;
            RMAP: begin
                bus.rd    = 1'b1;
                bus.rds   = 1'b1;
                bus.rsel  = ~ty[0];
                bus.raddr = {2'b10, tx, ty};
                next      = RT0;
            end
            RT0: begin
                bus.rd    = 1'b1;
                bus.raddr = {2'b01, bus.rdata[6:0], yl, 1'b0};
                next      = RT1;
            end
            RT1: begin
                bus.rd    = 1'b1;
                bus.raddr = {2'b01, tile[6:0], yl, 1'b1};
                next      = LAT;
            end
            LAT: next = EMIT;
            EMIT: begin
                bus.pix_valid = 1'b1;
                bus.pix_x     = {tx, i};
                bus.pix_color = {pal, cur_pix};
                bus.pix_prio  = tile[7];
                if (bus.pix_ready && i == 3'd7)
                    next = (tx == LAST_TX) ? DONE : RMAP;
            end
            DONE: begin
                line_done = 1'b1;
                next      = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
